// File: rtl/spi_bus_arbiter_if.sv
// Engine-side and pin-side signals of the SPI bus arbiter.
// The arbiter uses the slave modport. Engines, or a bench that stands in for them, use the master modport.
interface spi_bus_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] spc_in;
  logic [NREQ-1:0] cs_in;
  logic [NREQ-1:0] sdi_in;
  logic            tmo_clr;
  logic [NREQ-1:0] gnt;
  logic            SPC;
  logic            CS;
  logic            SDI;
  logic            busy;
  logic [OW-1:0]   owner;
  logic [NREQ-1:0] timeout_err;

  modport master (
    output req, done, spc_in, cs_in, sdi_in, tmo_clr,
    input  gnt, SPC, CS, SDI, busy, owner, timeout_err
  );

  modport slave (
    input  req, done, spc_in, cs_in, sdi_in, tmo_clr,
    output gnt, SPC, CS, SDI, busy, owner, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that grants one shared 4-wire SPI bus to one engine for a whole transaction.
// A CS-high gap follows every release, and a watchdog takes the bus back from an engine that hangs.
module spi_bus_arbiter #(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_bus_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   rr_q;
  logic [WW-1:0]   wdog_q;
  logic [GW-1:0]   gap_q;
  logic [NREQ-1:0] tmo_q;
  logic [1:0]      rsync_q;
  logic            rst_n_int;

  logic            done_own, req_own, wdog_hit, release_d;
  logic [NREQ-1:0] tmo_set_d, tmo_d;
  logic [OW-1:0]   pick_d, rr_next_d;

  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && r[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Reset asserts asynchronously, so the pins go idle at once, but it releases only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsync_q <= 2'b00;
    else          rsync_q <= {rsync_q[0], 1'b1};
  end
  assign rst_n_int = rsync_q[1];

  always_comb begin
    done_own  = bus.done[owner_q];
    req_own   = bus.req[owner_q];
    wdog_hit  = (wdog_q == WW'(TIMEOUT - 1));
    release_d = done_own || !req_own || wdog_hit;
    tmo_set_d = '0;
    // A done or an abort in the expiry cycle is an ordinary release, not a timeout.
    if (state_q == GRANT && wdog_hit && !done_own && req_own) tmo_set_d[owner_q] = 1'b1;
    tmo_d     = (tmo_q & ~{NREQ{bus.tmo_clr}}) | tmo_set_d;
    pick_d    = rr_pick(bus.req, rr_q);
    rr_next_d = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      tmo_q <= tmo_d;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q         <= GRANT;
            owner_q         <= pick_d;
            gnt_q           <= '0;
            gnt_q[pick_d]   <= 1'b1;
            wdog_q          <= '0;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q <= GAP;
            gnt_q   <= '0;
            gap_q   <= '0;
          end else if (wdog_q != WW'(TIMEOUT)) begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= IDLE;
            rr_q    <= rr_next_d;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The pins follow the owner combinationally, but only while the bus is granted.
  assign bus.SPC         = (state_q == GRANT) ? bus.spc_in[owner_q] : 1'b1;
  assign bus.CS          = (state_q == GRANT) ? bus.cs_in[owner_q]  : 1'b1;
  assign bus.SDI         = (state_q == GRANT) ? bus.sdi_in[owner_q] : 1'b0;
  assign bus.gnt         = gnt_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.owner       = owner_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with NREQ=2, GAP_CYCLES=16 and TIMEOUT=50.
module tb_spi_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  spi_bus_arbiter_if #(.NREQ(2)) bus ();

  spi_bus_arbiter #(.NREQ(2), .GAP_CYCLES(16), .TIMEOUT(50)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 2'b00; bus.done = 2'b00; bus.spc_in = 2'b00; bus.cs_in = 2'b00;
    bus.sdi_in = 2'b11; bus.tmo_clr = 1'b0;
    reset_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.SPC !== 1'b1) begin errors++; $display("FAIL reset_spc got=%b exp=1", bus.SPC); end
    checks++; if (bus.CS !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b exp=1", bus.CS); end
    checks++; if (bus.SDI !== 1'b0) begin errors++; $display("FAIL reset_sdi got=%b exp=0", bus.SDI); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", bus.owner); end
    checks++; if (bus.timeout_err !== 2'b00) begin errors++; $display("FAIL reset_tmo got=%b exp=00", bus.timeout_err); end
    reset_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single();
    int n;
    int csbad;
    bus.spc_in = 2'b10; bus.cs_in = 2'b10; bus.sdi_in = 2'b01;
    bus.req = 2'b01;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_latency got=%b exp=00", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", bus.gnt); end
    checks++; if ({bus.SPC, bus.CS, bus.SDI} !== 3'b001) begin errors++; $display("FAIL single_pins got=%b exp=001", {bus.SPC, bus.CS, bus.SDI}); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    bus.spc_in = 2'b11; bus.sdi_in = 2'b00;
    #1;
    checks++; if ({bus.SPC, bus.SDI} !== 2'b10) begin errors++; $display("FAIL single_follow got=%b exp=10", {bus.SPC, bus.SDI}); end
    bus.done = 2'b01; bus.req = 2'b00;
    step();
    bus.done = 2'b00;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_release got=%b exp=00", bus.gnt); end
    n = 0; csbad = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (bus.CS !== 1'b1) csbad++;
      step();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL single_gap_len got=%0d exp=16", n); end
    checks++; if (csbad != 0) begin errors++; $display("FAIL single_gap_cs got=%0d low cycles exp=0", csbad); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt [4];
    int n;
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    bus.cs_in = 2'b00;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.gnt === 2'b00 && n < 60) begin
        if (bus.CS === 1'b1) n++;
        step();
      end
      checks++; if (bus.gnt !== exp_gnt[k]) begin errors++; $display("FAIL b2b_gnt%0d got=%b exp=%b", k, bus.gnt, exp_gnt[k]); end
      checks++; if (bus.owner !== exp_gnt[k][1]) begin errors++; $display("FAIL b2b_owner%0d got=%b exp=%b", k, bus.owner, exp_gnt[k][1]); end
      if (k > 0) begin
        checks++; if (n != 17) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=17", k, n); end
      end
      repeat (3) step();
      checks++; if (bus.CS !== 1'b0) begin errors++; $display("FAIL b2b_cs%0d got=%b exp=0", k, bus.CS); end
      bus.done = exp_gnt[k];
      if (k == 3) bus.req = 2'b00;
      step();
      bus.done = 2'b00;
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_timeout();
    int n;
    bus.req = 2'b01;
    step();
    n = 0;
    while (bus.gnt === 2'b01 && n < 200) begin n++; step(); end
    bus.req = 2'b00;
    checks++; if (n != 50) begin errors++; $display("FAIL tmo_hold got=%0d exp=50", n); end
    checks++; if (bus.timeout_err !== 2'b01) begin errors++; $display("FAIL tmo_err got=%b exp=01", bus.timeout_err); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_gap got=%b exp=1", bus.busy); end
    step();
    checks++; if (bus.timeout_err !== 2'b01) begin errors++; $display("FAIL tmo_sticky got=%b exp=01", bus.timeout_err); end
    bus.tmo_clr = 1'b1;
    step();
    bus.tmo_clr = 1'b0;
    checks++; if (bus.timeout_err !== 2'b00) begin errors++; $display("FAIL tmo_clr got=%b exp=00", bus.timeout_err); end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
  endtask

  task automatic test_isolation_abort();
    logic [1:0] pat [4];
    int n;
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11;
    bus.spc_in = 2'b01; bus.cs_in = 2'b00; bus.sdi_in = 2'b00;
    bus.req = 2'b01;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.spc_in[1] = pat[k][0]; bus.cs_in[1] = pat[k][1]; bus.sdi_in[1] = pat[k][0];
      #1;
      checks++; if ({bus.SPC, bus.CS, bus.SDI} !== 3'b100) begin errors++; $display("FAIL iso_pins%0d got=%b exp=100", k, {bus.SPC, bus.CS, bus.SDI}); end
    end
    bus.done = 2'b10;
    step();
    bus.done = 2'b00;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL iso_done1 got=%b exp=01", bus.gnt); end
    bus.req = 2'b00;
    step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL abort_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_gap got=%b exp=1", bus.busy); end
    checks++; if (bus.timeout_err !== 2'b00) begin errors++; $display("FAIL abort_tmo got=%b exp=00", bus.timeout_err); end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
  endtask

  task automatic test_done_at_expiry();
    int n;
    bus.req = 2'b01;
    step();
    repeat (49) step();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL expiry_hold got=%b exp=01", bus.gnt); end
    bus.done = 2'b01; bus.req = 2'b00;
    step();
    bus.done = 2'b00;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL expiry_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.timeout_err !== 2'b00) begin errors++; $display("FAIL expiry_tmo got=%b exp=00", bus.timeout_err); end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
  endtask

  task automatic test_reset_mid_grant();
    bus.spc_in = 2'b00; bus.cs_in = 2'b00; bus.sdi_in = 2'b01;
    bus.req = 2'b01;
    step();
    checks++; if ({bus.SPC, bus.CS} !== 2'b00) begin errors++; $display("FAIL rstmid_pre got=%b exp=00", {bus.SPC, bus.CS}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.SPC, bus.CS, bus.SDI} !== 3'b110) begin errors++; $display("FAIL rstmid_pins got=%b exp=110", {bus.SPC, bus.CS, bus.SDI}); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    bus.req = 2'b00;
    step();
    reset_n = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_isolation_abort();
    test_done_at_expiry();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
